// File: rtl/jt89_pkg.sv
// jt89_pkg: constants and types shared by the jt89 write queue and its benches.
//   JT89_WR_GAP - default number of clken periods between replayed writes
//   JT89_CNT_W  - width of the inter-write gap counter
//   wrq_st_e    - replay FSM state encoding
package jt89_pkg;

    localparam int JT89_WR_GAP = 32;
    localparam int JT89_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } wrq_st_e;

endpackage

// File: rtl/jt89_wrq_fifo.sv
// jt89_wrq_fifo: small synchronous FIFO for the jt89 write queue.
//   clk, rst : clock, async active-high reset (pointers and level only)
//   push     : write wdata at the tail on this edge
//   pop      : advance the head on this edge (rdata shows the head beforehand)
//   rdata    : current head entry (combinational read)
//   level    : occupancy, 0..DEPTH
// Caller guarantees push is never asserted while full unless pop is also
// asserted on the same edge.
module jt89_wrq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Storage is not reset; only entries below level are ever observed.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;

    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/jt89_wrq.sv
// jt89_wrq: CPU write queue in front of the jt89 PSG core.
//   clk, rst  : system clock, async active-high reset
//   clken     : the clock enable also fed to jt89; paces the replay gap
//   cs_n,wr_n : CPU bus strobe (active low); one entry per strobe assertion
//   din       : CPU write data
//   ready     : a new CPU write can be accepted (FIFO not full)
//   ovf       : sticky, a write was dropped because the FIFO was full
//   core_wr_n : one-cycle write pulse to jt89
//   core_din  : data to jt89, holds the last issued byte
//   level     : FIFO occupancy
module jt89_wrq
    import jt89_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = JT89_WR_GAP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clken,
    input  logic                     cs_n,
    input  logic                     wr_n,
    input  logic [7:0]               din,
    output logic                     ready,
    output logic                     ovf,
    output logic                     core_wr_n,
    output logic [7:0]               core_din,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                  stb, stb_q, acc;
    logic                  full, empty;
    logic                  push, pop;
    logic [7:0]            head;
    wrq_st_e               state, state_nxt;
    logic [JT89_CNT_W-1:0] gap_cnt, gap_nxt;

    // Edge-detect the strobe so a long CPU write lands exactly once.
    assign stb   = !cs_n && !wr_n;
    assign acc   = stb && !stb_q;
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign ready = !full;

    // A full FIFO still takes the write if the head leaves on the same edge.
    assign push = acc && (!full || pop);

    jt89_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (din),
        .rdata (head),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q    <= 1'b0;
            ovf      <= 1'b0;
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            core_din <= 8'h00;
        end else begin
            stb_q   <= stb;
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (acc && full && !pop) ovf <= 1'b1;
            if (pop) core_din <= head;
        end
    end

    // Pop decision uses registered level, so a fresh push into an empty
    // queue is only seen on the following edge.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        case (state)
            ST_IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                gap_nxt   = JT89_CNT_W'(GAP);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (gap_cnt == '0)  state_nxt = ST_IDLE;
                else if (clken)     gap_nxt   = gap_cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Decoded from state so an async reset cuts the pulse immediately.
    assign core_wr_n = (state != ST_ISSUE);

endmodule

// File: tb/tb_jt89_wrq.sv
module tb_jt89_wrq;
    import jt89_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = JT89_WR_GAP;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0, rst = 1'b1, clken = 1'b0;
    logic          cs_n = 1'b1, wr_n = 1'b1;
    logic [7:0]    din = 8'h00;
    logic          ready, ovf, core_wr_n;
    logic [7:0]    core_din;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    jt89_wrq #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .clken(clken), .cs_n(cs_n), .wr_n(wr_n),
        .din(din), .ready(ready), .ovf(ovf), .core_wr_n(core_wr_n),
        .core_din(core_din), .level(level)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // clken generator: one high cycle every ck_div clocks while ck_run.
    int ck_div = 16, ck_cnt = 0;
    bit ck_run = 1'b1;
    always @(negedge clk) begin
        clken = ck_run && (ck_cnt >= ck_div - 1);
        if (ck_cnt >= ck_div - 1) ck_cnt = 0; else ck_cnt++;
    end

    // Reference model: a byte queue plus the replay pacing rules.
    // m_pulse: a write is on the core bus this cycle.
    // m_cool : clken periods still to wait after a pulse (-1 = free to issue).
    logic [7:0] m_q[$];
    logic [7:0] iss_q[$];
    logic [7:0] m_din;
    bit         m_stbq, m_pulse, m_ovf;
    int         m_cool;
    int         cyc = 0, last_pulse = -1, ck_since = 0, pulses = 0;

    function automatic void m_reset();
        m_q.delete();
        m_din      = 8'h00;
        m_stbq     = 1'b0;
        m_pulse    = 1'b0;
        m_ovf      = 1'b0;
        m_cool     = -1;
        last_pulse = -1;
    endfunction

    initial m_reset();

    bit stb_v, acc_v, pop_v;
    int sz;
    always @(posedge clk) begin
        if (rst) m_reset();
        else begin
            stb_v  = !cs_n && !wr_n;
            acc_v  = stb_v && !m_stbq;
            m_stbq = stb_v;
            sz     = m_q.size();
            pop_v  = !m_pulse && m_cool < 0 && sz > 0;
            if (pop_v) m_din = m_q.pop_front();
            if (acc_v) begin
                if (sz == DEPTH && !pop_v) m_ovf = 1'b1;
                else m_q.push_back(din);
            end
            if (pop_v)             m_pulse = 1'b1;
            else if (m_pulse)      begin m_pulse = 1'b0; m_cool = GAP; end
            else if (m_cool == 0)  m_cool = -1;
            else if (m_cool > 0 && clken) m_cool--;
            if (clken) ck_since++;
        end
        cyc++;
        #1;
        if (!rst) begin
            check("core_wr_n", core_wr_n, !m_pulse);
            check("core_din",  core_din,  m_din);
            check("level",     level,     m_q.size());
            check("ready",     ready,     m_q.size() != DEPTH);
            check("ovf",       ovf,       m_ovf);
            if (!core_wr_n) begin
                if (last_pulse >= 0) begin
                    check("gap_clken", ck_since >= GAP, 1);
                    check("gap_clk",   (cyc - last_pulse) >= GAP + 2, 1);
                end
                iss_q.push_back(core_din);
                pulses++;
                last_pulse = cyc;
                ck_since   = 0;
            end
        end
    end

    // Called at a negedge; leaves at a negedge.
    task automatic do_write(input logic [7:0] d, input int len, input int gap);
        cs_n = 1'b0; wr_n = 1'b0; din = d;
        repeat (len) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while ((m_q.size() != 0 || m_pulse || m_cool >= 0) && n < max) begin
            @(negedge clk); n++;
        end
        check(tag, n < max, 1);
    endtask

    task automatic wait_pulse(input string tag, input int max);
        int n = 0;
        while (!m_pulse && n < max) begin
            @(negedge clk); n++;
        end
        check(tag, n < max, 1);
    endtask

    task automatic check_seq(input string tag, input logic [7:0] exp[$]);
        check({tag, "_cnt"}, iss_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < iss_q.size(); i++)
            check(tag, iss_q[i], exp[i]);
    endtask

    int p0;
    logic [7:0] burst[$] = '{8'h80, 8'h05, 8'h90, 8'hA3, 8'h12};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_core_wr_n", core_wr_n, 1);
        check("rst_core_din",  core_din,  0);
        check("rst_ready",     ready,     1);
        check("rst_ovf",       ovf,       0);
        check("rst_level",     level,     0);
        rst = 1'b0;
        @(negedge clk);

        // Single write, long strobe: one pulse only.
        iss_q.delete(); p0 = pulses;
        do_write(8'h9F, 3, 1);
        wait_idle("t1_idle", 2000);
        check("t1_pulses", pulses - p0, 1);
        check("t1_level", level, 0);
        check_seq("t1_data", '{8'h9F});

        // Burst of five into an idle queue: first leaves early, none dropped.
        iss_q.delete();
        foreach (burst[i]) do_write(burst[i], 1, 1);
        check("t2_ovf", ovf, 0);
        wait_idle("t2_idle", 5000);
        check_seq("t2_data", burst);

        // Push on the very edge that pops a full queue.
        iss_q.delete();
        do_write(8'h21, 1, 1);
        wait_pulse("t4_pulse", 100);
        for (int i = 0; i < 4; i++) do_write(8'h31 + 8'(i), 1, 1);
        check("t4_full_level", level, 4);
        check("t4_full_ready", ready, 0);
        begin
            int n = 0;
            while (!(!m_pulse && m_cool < 0 && m_q.size() > 0) && n < 2000) begin
                @(negedge clk); n++;
            end
            check("t4_popwait", n < 2000, 1);
        end
        do_write(8'h35, 1, 0);
        check("t4_level", level, 4);
        check("t4_ready", ready, 0);
        check("t4_ovf", ovf, 0);
        wait_idle("t4_idle", 5000);
        check_seq("t4_data", '{8'h21, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35});

        // Overflow: five writes while the replay is waiting.
        iss_q.delete();
        do_write(8'h11, 1, 1);
        wait_pulse("t3_pulse", 100);
        for (int i = 0; i < 4; i++) do_write(burst[i], 1, 1);
        check("t3_ready4", ready, 0);
        do_write(burst[4], 1, 1);
        check("t3_ovf", ovf, 1);
        check("t3_level", level, 4);
        wait_idle("t3_idle", 5000);
        check("t3_ovf_sticky", ovf, 1);
        check_seq("t3_data", '{8'h11, 8'h80, 8'h05, 8'h90, 8'hA3});

        // clken stuck low freezes the replay.
        do_write(8'h42, 1, 1);
        wait_pulse("t5_pulse", 100);
        @(negedge clk);
        ck_run = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 3; i++) do_write(8'h60 + 8'(i), 2, 1);
        repeat (200) @(negedge clk);
        check("t5_level", level, 3);
        check("t5_nopulse", pulses - p0, 0);
        ck_run = 1'b1;
        wait_idle("t5_idle", 5000);
        check("t5_resume", pulses - p0, 3);

        // Reset in the middle of an issue cycle, with data still queued.
        do_write(8'h54, 1, 1);
        wait_pulse("t6_pulse0", 100);
        @(negedge clk);
        do_write(8'h55, 1, 1);
        do_write(8'h56, 1, 1);
        wait_pulse("t6_pulse1", 2000);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check("t6_core_wr_n", core_wr_n, 1);
        check("t6_level", level, 0);
        check("t6_ready", ready, 1);
        check("t6_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        repeat (100) @(negedge clk);
        check("t6_nopulse", pulses - p0, 0);

        // Randomised traffic against the model.
        for (int seg = 0; seg < 4; seg++) begin
            ck_div = $urandom_range(1, 4);
            for (int i = 0; i < 15; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    cs_n = 1'b0; din = 8'($urandom);   // chip select without write
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    cs_n = 1'b1;
                    @(negedge clk);
                end
                do_write(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 7));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(10, 60)) @(negedge clk);
            end
            wait_idle("rnd_idle", 8000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
